mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, giving the data and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, giving the number of DATA_W-bit words in the data RAM; it SHALL be a power of two.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, giving the extra wait cycles per memory access; legal range is 0..7.
REQ-004 SHALL have parameter RD_W, default 3, giving the destination-register index width.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 valid_in  in  1  the upstream EX/MEM register holds an instruction.
REQ-008 ready_out  out  1  this stage accepts valid_in this cycle; low means stall upstream.
REQ-009 mem_read / mem_write  in  1 each  load / store request.
REQ-010 size_byte  in  1  0 = word access, 1 = byte access.
REQ-011 sign_ext  in  1  sign-extends byte loads when 1, zero-extends when 0.
REQ-012 alu_result  in  DATA_W  byte address for memory ops, pass-through value otherwise.
REQ-013 write_data  in  DATA_W  store data; byte stores use bits [7:0].
REQ-014 rd_in / reg_write_in  in  RD_W / 1  writeback tag, carried through.
REQ-015 valid_out  out  1  one-cycle pulse marking a completed instruction toward MEM/WB.
REQ-016 read_data / mem_alu_result  out  DATA_W each  load result / registered alu_result.
REQ-017 rd_out / reg_write_out  out  RD_W / 1  registered tag.
REQ-018 mem_err  out  1  accompanies valid_out when the access was misaligned or out of range.

Function
REQ-019 SHALL implement the FSM IDLE -> (memory op accepted, WAIT_CYCLES>0) WAIT -> DONE -> IDLE; with WAIT_CYCLES=0 an accepted memory op SHALL go IDLE -> DONE.
REQ-020 ready_out SHALL be 1 only in IDLE, and also in DONE when valid_out fires, so that back-to-back issue is allowed.
REQ-021 A non-memory instruction SHALL complete in 1 cycle: valid_out the cycle after acceptance, with read_data = 0.
REQ-022 A memory op SHALL assert valid_out exactly WAIT_CYCLES+1 cycles after acceptance; the WAIT counter SHALL count down from WAIT_CYCLES-1 to 0.
REQ-023 A word access SHALL use index alu_result[log2(DEPTH):1]; a byte access SHALL select the low byte when addr[0]=0 and the high byte when addr[0]=1 (little-endian).
REQ-024 A word access with addr[0]=1, or any address >= 2*DEPTH, SHALL suppress the write, force read_data = 0, force reg_write_out = 0, and set mem_err = 1.
REQ-025 When mem_read and mem_write are both 1, the write SHALL take priority and the op SHALL be treated as a store.
REQ-026 A store SHALL force reg_write_out = 0; a byte store SHALL modify only the addressed byte.
REQ-027 All inputs SHALL be captured at acceptance; input changes during WAIT SHALL be ignored.
REQ-028 mem_alu_result, rd_out and mem_err SHALL hold their values until the next valid_out.

Reset
REQ-029 On rst the FSM SHALL go to IDLE, the counter to 0, and valid_out, reg_write_out, mem_err, read_data, mem_alu_result and rd_out to 0; ready_out SHALL be 1 after release.
REQ-030 A reset asserted mid-access SHALL abort it: no valid_out, and no write if the write was not yet committed.
REQ-031 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-032 The FSM state encoding and the size_byte codes SHALL live in the shared package microrisc_pkg.
REQ-033 The RAM SHALL be the sub-module dmem_bank: synchronous write with per-byte enables, and registered read.
REQ-034 The write SHALL commit on the DONE entry edge.

Verification
REQ-035 Reset for 3 cycles, then word store 0xABCD to address 0x0004, then word load from 0x0004 -> read_data = 0xABCD, with valid_out 2 cycles after each acceptance (WAIT_CYCLES=1).
REQ-036 Byte store 0x80 to address 0x0005, then a byte load with sign_ext=1 -> 0xFF80; with sign_ext=0 -> 0x0080; a word load at 0x0004 -> 0x80CD.
REQ-037 Word load at 0x0003 -> mem_err=1, read_data=0, reg_write_out=0; the RAM is unchanged.
REQ-038 Non-memory op with alu_result=0x1234, rd_in=5 -> one cycle later valid_out=1, mem_alu_result=0x1234, rd_out=5, ready_out stays high.
REQ-039 Hold valid_in high with 3 back-to-back loads -> ready_out low during WAIT, and exactly 3 valid_out pulses in order.
REQ-040 Assert rst during WAIT of a store to 0x0010 -> no valid_out, and a later load of 0x0010 returns the prior contents.

Source files
------------

// File: rtl/microrisc_pkg.sv
// Shared definitions for the memory-access stage: FSM state encoding,
// access-size codes and a small decode helper.
package microrisc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mau_state_t;

    // size_byte input codes
    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

    // An instruction touches memory when it is a load or a store.
    function automatic logic is_mem_op(input logic rd_req, input logic wr_req);
        return rd_req | wr_req;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Data RAM: one 8-bit lane per byte of the word, synchronous write with
// per-byte enables, registered read (read-before-write on the same address).
module dmem_bank #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 256,
    localparam int AW     = $clog2(DEPTH),
    localparam int NB     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [NB-1:0]     be,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_q;

            // Byte-lane write plus registered read; contents are never reset.
            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    mem[addr] <= wdata[gi*8 +: 8];
                end
                rd_q <= mem[addr];
            end

            assign rdata[gi*8 +: 8] = rd_q;
        end
    endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage. Accepts one instruction from EX/MEM, performs
// an optional load/store against the data RAM with a fixed number of wait
// cycles, and presents the result to MEM/WB as a one-cycle valid pulse.
module mem_access_unit #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1,
    parameter int RD_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              size_byte,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] write_data,
    input  logic [RD_W-1:0]   rd_in,
    input  logic              reg_write_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [RD_W-1:0]   rd_out,
    output logic              reg_write_out,
    output logic              mem_err
);
    import microrisc_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;
    localparam logic [2:0] CNT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    mau_state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    // Instruction captured at acceptance, used while waiting.
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              rw_q, rw_d;
    logic              ld_q, ld_d;
    logic              st_q, st_d;
    logic              size_q, size_d;
    logic              sext_q, sext_d;

    // Result registers toward MEM/WB; they load only on DONE entry so they
    // hold between completions.
    logic [DATA_W-1:0] alu_out_q, alu_out_d;
    logic [RD_W-1:0]   rd_out_q, rd_out_d;
    logic              rw_out_q, rw_out_d;
    logic              err_out_q, err_out_d;
    logic              ld_ok_q, ld_ok_d;
    logic              byte_out_q, byte_out_d;
    logic              sext_out_q, sext_out_d;
    logic              hi_out_q, hi_out_d;

    // View of the instruction being worked on: live inputs when a new one is
    // being accepted, the captured copy while waiting.
    logic [DATA_W-1:0] c_addr, c_wdata;
    logic [RD_W-1:0]   c_rd;
    logic              c_rw, c_ld, c_st, c_size, c_sext;
    logic              c_oor, c_err;

    logic              accept;
    logic              ram_we;
    logic [NB-1:0]     ram_be;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic [7:0]        byte_sel;

    assign ready_out = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept    = valid_in && ready_out;

    // Select the live or captured instruction fields.
    always_comb begin
        if (state_q == ST_WAIT) begin
            c_addr  = addr_q;
            c_wdata = wdata_q;
            c_rd    = rd_q;
            c_rw    = rw_q;
            c_ld    = ld_q;
            c_st    = st_q;
            c_size  = size_q;
            c_sext  = sext_q;
        end else begin
            c_addr  = alu_result;
            c_wdata = write_data;
            c_rd    = rd_in;
            c_rw    = reg_write_in;
            c_ld    = mem_read & ~mem_write;   // a simultaneous write wins
            c_st    = mem_write;
            c_size  = size_byte;
            c_sext  = sign_ext;
        end
    end

    // Addresses at or beyond 2*DEPTH bytes are out of range.
    generate
        if (AW + 1 < DATA_W) begin : g_range
            assign c_oor = |c_addr[DATA_W-1:AW+1];
        end else begin : g_norange
            assign c_oor = 1'b0;
        end
    endgenerate

    assign c_err = is_mem_op(c_ld, c_st) &&
                   (((c_size == SIZE_WORD) && c_addr[0]) || c_oor);

    // Next-state, wait counter, capture and result-register logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        ld_d       = ld_q;
        st_d       = st_q;
        size_d     = size_q;
        sext_d     = sext_q;
        alu_out_d  = alu_out_q;
        rd_out_d   = rd_out_q;
        rw_out_d   = rw_out_q;
        err_out_d  = err_out_q;
        ld_ok_d    = ld_ok_q;
        byte_out_d = byte_out_q;
        sext_out_d = sext_out_q;
        hi_out_d   = hi_out_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    addr_d  = c_addr;
                    wdata_d = c_wdata;
                    rd_d    = c_rd;
                    rw_d    = c_rw;
                    ld_d    = c_ld;
                    st_d    = c_st;
                    size_d  = c_size;
                    sext_d  = c_sext;
                    if (is_mem_op(c_ld, c_st) && (WAIT_CYCLES > 0)) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_DONE) begin
            alu_out_d  = c_addr;
            rd_out_d   = c_rd;
            rw_out_d   = c_rw & ~c_st & ~c_err;
            err_out_d  = c_err;
            ld_ok_d    = c_ld & ~c_err;
            byte_out_d = (c_size == SIZE_BYTE);
            sext_out_d = c_sext;
            hi_out_d   = c_addr[0];
        end
    end

    // RAM port: the address follows the current instruction every cycle so
    // the registered read lands on DONE entry; the store commits on that edge.
    always_comb begin
        ram_we    = (state_d == ST_DONE) && c_st && !c_err && !rst;
        ram_be    = '1;
        ram_wdata = c_wdata;
        if (c_size == SIZE_BYTE) begin
            ram_be    = c_addr[0] ? NB'(2) : NB'(1);
            ram_wdata = {NB{c_wdata[7:0]}};
        end
    end

    dmem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_dmem (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (c_addr[AW:1]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // State, counter, capture and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            ld_q       <= 1'b0;
            st_q       <= 1'b0;
            size_q     <= 1'b0;
            sext_q     <= 1'b0;
            alu_out_q  <= '0;
            rd_out_q   <= '0;
            rw_out_q   <= 1'b0;
            err_out_q  <= 1'b0;
            ld_ok_q    <= 1'b0;
            byte_out_q <= 1'b0;
            sext_out_q <= 1'b0;
            hi_out_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            rw_q       <= rw_d;
            ld_q       <= ld_d;
            st_q       <= st_d;
            size_q     <= size_d;
            sext_q     <= sext_d;
            alu_out_q  <= alu_out_d;
            rd_out_q   <= rd_out_d;
            rw_out_q   <= rw_out_d;
            err_out_q  <= err_out_d;
            ld_ok_q    <= ld_ok_d;
            byte_out_q <= byte_out_d;
            sext_out_q <= sext_out_d;
            hi_out_q   <= hi_out_d;
        end
    end

    // Load formatting: byte lane select and sign/zero extension; zero unless
    // a successful load is completing.
    always_comb begin
        byte_sel  = hi_out_q ? ram_rdata[15:8] : ram_rdata[7:0];
        read_data = '0;
        if (valid_out && ld_ok_q) begin
            if (byte_out_q) begin
                read_data = {{(DATA_W-8){sext_out_q & byte_sel[7]}}, byte_sel};
            end else begin
                read_data = ram_rdata;
            end
        end
    end

    assign valid_out      = (state_q == ST_DONE);
    assign mem_alu_result = alu_out_q;
    assign rd_out         = rd_out_q;
    assign reg_write_out  = rw_out_q;
    assign mem_err        = err_out_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes the expected
// completion, a negedge monitor pops and compares on every valid_out.
module tb_mem_access_unit;

    localparam int DATA_W      = 16;
    localparam int DEPTH       = 256;
    localparam int WAIT_CYCLES = 1;
    localparam int RD_W        = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              valid_in = 1'b0;
    logic              ready_out;
    logic              mem_read = 1'b0;
    logic              mem_write = 1'b0;
    logic              size_byte = 1'b0;
    logic              sign_ext = 1'b0;
    logic [DATA_W-1:0] alu_result = '0;
    logic [DATA_W-1:0] write_data = '0;
    logic [RD_W-1:0]   rd_in = '0;
    logic              reg_write_in = 1'b0;
    logic              valid_out;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] mem_alu_result;
    logic [RD_W-1:0]   rd_out;
    logic              reg_write_out;
    logic              mem_err;

    mem_access_unit #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES),
        .RD_W        (RD_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .size_byte      (size_byte),
        .sign_ext       (sign_ext),
        .alu_result     (alu_result),
        .write_data     (write_data),
        .rd_in          (rd_in),
        .reg_write_in   (reg_write_in),
        .valid_out      (valid_out),
        .read_data      (read_data),
        .mem_alu_result (mem_alu_result),
        .rd_out         (rd_out),
        .reg_write_out  (reg_write_out),
        .mem_err        (mem_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] alu;
        logic [RD_W-1:0]   rd;
        logic              rw;
        logic              err;
        int                cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endfunction

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid_out: got valid_out=1 at cycle %0d, expected no completion", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                n_txn++;
                $display("txn %0d cyc %0d: alu=0x%04h rd=%0d rdata=0x%04h rw=%0b err=%0b",
                         n_txn, cyc, mem_alu_result, rd_out, read_data, reg_write_out, mem_err);
                check("latency_cycle",  cyc,            mon_e.cyc);
                check("read_data",      read_data,      mon_e.rdata);
                check("mem_alu_result", mem_alu_result, mon_e.alu);
                check("rd_out",         rd_out,         mon_e.rd);
                check("reg_write_out",  reg_write_out,  mon_e.rw);
                check("mem_err",        mem_err,        mon_e.err);
            end
        end
    end

    // Present one instruction, wait for acceptance, queue its expectation.
    // Called and returns 1ns after a rising edge; valid_in is left high.
    task automatic issue(input logic rd_op, input logic wr_op, input logic sz, input logic sx,
                         input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] wd,
                         input logic [RD_W-1:0] rd, input logic rw,
                         input logic [DATA_W-1:0] e_rdata, input logic e_err, input logic e_rw,
                         input bit push);
        exp_t e;
        int   n;
        valid_in     = 1'b1;
        mem_read     = rd_op;
        mem_write    = wr_op;
        size_byte    = sz;
        sign_ext     = sx;
        alu_result   = addr;
        write_data   = wd;
        rd_in        = rd;
        reg_write_in = rw;
        n = 0;
        while (ready_out !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (ready_out !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got ready_out=%0b after %0d cycles, expected 1", ready_out, n);
            return;
        end
        if (push) begin
            e.rdata = e_rdata;
            e.alu   = addr;
            e.rd    = rd;
            e.rw    = e_rw;
            e.err   = e_err;
            e.cyc   = cyc + 1 + ((rd_op | wr_op) ? WAIT_CYCLES : 0);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Drop valid and scramble the operand inputs.
    task automatic drop();
        valid_in     = 1'b0;
        mem_read     = 1'($urandom);
        mem_write    = 1'($urandom);
        size_byte    = 1'($urandom);
        sign_ext     = 1'($urandom);
        alu_result   = DATA_W'($urandom);
        write_data   = DATA_W'($urandom);
        rd_in        = RD_W'($urandom);
        reg_write_in = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d completions outstanding, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int base;

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_valid_out",      valid_out,      1'b0);
        check("rst_read_data",      read_data,      16'h0);
        check("rst_mem_alu_result", mem_alu_result, 16'h0);
        check("rst_rd_out",         rd_out,         3'd0);
        check("rst_reg_write_out",  reg_write_out,  1'b0);
        check("rst_mem_err",        mem_err,        1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready_out", ready_out, 1'b1);

        // Word store then word load
        issue(0, 1, 0, 0, 16'h0004, 16'hABCD, 3'd1, 1, 16'h0000, 0, 0, 1);
        issue(1, 0, 0, 0, 16'h0004, 16'h0000, 3'd2, 1, 16'hABCD, 0, 1, 1);
        // Byte store to the high byte (only bits [7:0] of write_data used)
        issue(0, 1, 1, 0, 16'h0005, 16'h1280, 3'd3, 1, 16'h0000, 0, 0, 1);
        issue(1, 0, 1, 1, 16'h0005, 16'h0000, 3'd4, 1, 16'hFF80, 0, 1, 1);
        issue(1, 0, 1, 0, 16'h0005, 16'h0000, 3'd4, 1, 16'h0080, 0, 1, 1);
        issue(1, 0, 0, 0, 16'h0004, 16'h0000, 3'd6, 1, 16'h80CD, 0, 1, 1);
        issue(1, 0, 1, 1, 16'h0004, 16'h0000, 3'd7, 1, 16'hFFCD, 0, 1, 1);
        // Misaligned / out-of-range accesses; 0x0204 aliases word index 2
        issue(1, 0, 0, 0, 16'h0003, 16'h0000, 3'd1, 1, 16'h0000, 1, 0, 1);
        issue(0, 1, 0, 0, 16'h0005, 16'hDEAD, 3'd1, 1, 16'h0000, 1, 0, 1);
        issue(0, 1, 0, 0, 16'h0204, 16'h7777, 3'd2, 1, 16'h0000, 1, 0, 1);
        issue(1, 0, 0, 0, 16'h0200, 16'h0000, 3'd3, 1, 16'h0000, 1, 0, 1);
        drop();
        drain();
        idle(2);
        check("hold_mem_err", mem_err, 1'b1);
        issue(1, 0, 0, 0, 16'h0004, 16'h0000, 3'd5, 1, 16'h80CD, 0, 1, 1);
        // Last in-range word
        issue(0, 1, 0, 0, 16'h01FE, 16'h1357, 3'd1, 1, 16'h0000, 0, 0, 1);
        issue(1, 0, 0, 0, 16'h01FE, 16'h0000, 3'd2, 1, 16'h1357, 0, 1, 1);
        // Read and write together behave as a store
        issue(1, 1, 0, 0, 16'h0008, 16'h4242, 3'd3, 1, 16'h0000, 0, 0, 1);
        issue(1, 0, 0, 0, 16'h0008, 16'h0000, 3'd4, 1, 16'h4242, 0, 1, 1);
        drop();
        drain();

        // Non-memory pass-through
        issue(0, 0, 0, 0, 16'h1234, 16'h5555, 3'd5, 1, 16'h0000, 0, 1, 1);
        check("nonmem_ready_out", ready_out, 1'b1);
        drop();
        drain();
        idle(3);
        check("hold_mem_alu_result", mem_alu_result, 16'h1234);
        check("hold_rd_out",         rd_out,         3'd5);

        // Back-to-back loads with valid_in held high
        base = n_txn;
        issue(1, 0, 0, 0, 16'h0004, 16'h0000, 3'd1, 1, 16'h80CD, 0, 1, 1);
        check("b2b_ready_wait1", ready_out, 1'b0);
        issue(1, 0, 0, 0, 16'h0008, 16'h0000, 3'd2, 1, 16'h4242, 0, 1, 1);
        check("b2b_ready_wait2", ready_out, 1'b0);
        issue(1, 0, 1, 0, 16'h01FF, 16'h0000, 3'd3, 0, 16'h0013, 0, 0, 1);
        check("b2b_ready_wait3", ready_out, 1'b0);
        drop();
        drain();
        check("b2b_pulses", n_txn - base, 3);

        // Reset during WAIT of a store aborts it
        issue(0, 1, 0, 0, 16'h0010, 16'h5A5A, 3'd1, 1, 16'h0000, 0, 0, 1);
        drop();
        drain();
        issue(0, 1, 0, 0, 16'h0010, 16'h1111, 3'd2, 1, 16'h0000, 0, 0, 0);
        drop();
        rst = 1'b1;
        #1;
        check("abort_valid_out", valid_out, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(3);
        check("abort_ready_out", ready_out, 1'b1);
        issue(1, 0, 0, 0, 16'h0010, 16'h0000, 3'd6, 1, 16'h5A5A, 0, 1, 1);
        drop();
        drain();

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
